// File: rtl/seq_multi_nbits.sv
// ============================================================================
//  Module   : seq_multi_nbits
//  Purpose  : Serial shift-and-add multiplier, BITS x BITS -> 2*BITS, with
//             unsigned/signed mode and a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multi_nbits #(
    parameter int BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [BITS-1:0]   A_i,
    input  logic [BITS-1:0]   B_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*BITS-1:0] Product_o
);

    localparam int                 c_cnt_w    = $clog2(BITS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [BITS-1:0]     r_mcand;
    logic [BITS-1:0]     r_mplier;
    logic [2*BITS:0]     r_acc;
    logic                r_neg;
    logic                r_done;
    logic [2*BITS-1:0]   r_prod;

    logic                w_accept;
    logic [BITS-1:0]     w_a_mag;
    logic [BITS-1:0]     w_b_mag;
    logic [BITS-1:0]     w_addend;
    logic [BITS:0]       w_sum;
    logic [2*BITS:0]     w_acc_step;
    logic [2*BITS-1:0]   w_fix_val;

    assign w_accept = start_i && ((r_state == c_idle) || (r_state == c_done));

    // Signed operands are reduced to magnitudes; -2^(BITS-1) maps to 2^(BITS-1),
    // which still fits in BITS unsigned bits.
    assign w_a_mag = (signed_i && A_i[BITS-1]) ? -A_i : A_i;
    assign w_b_mag = (signed_i && B_i[BITS-1]) ? -B_i : B_i;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_sum      = r_acc[2*BITS:BITS] + {1'b0, w_addend};
    assign w_acc_step = {w_sum, r_acc[BITS-1:0]} >> 1;
    assign w_fix_val  = r_neg ? -r_acc[2*BITS-1:0] : r_acc[2*BITS-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_next = c_run;
            c_run:   if (r_cnt == c_cnt_one) w_next = c_fix;
            c_fix:   w_next = c_done;
            c_done:  if (w_accept) w_next = c_run;
            default: w_next = c_idle;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o = (r_state == c_run) || (r_state == c_fix);
    end

    assign done_o    = r_done;
    assign Product_o = r_prod;

    // Datapath: operand capture, iteration and result write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_prod   <= '0;
        end else begin
            if (w_accept) begin
                r_mcand  <= w_a_mag;
                r_mplier <= w_b_mag;
                r_neg    <= signed_i && (A_i[BITS-1] ^ B_i[BITS-1]);
                r_cnt    <= c_cnt_init;
                r_acc    <= '0;
            end else if (r_state == c_run) begin
                r_acc    <= w_acc_step;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - c_cnt_one;
            end
            if (r_state == c_fix) begin
                r_prod <= w_fix_val;
            end
            r_done <= (r_state == c_fix);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_multi_nbits.sv
// ============================================================================
//  Module   : tb_seq_multi_nbits
//  Purpose  : Self-checking bench for seq_multi_nbits at BITS=4 and BITS=8.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_multi_nbits;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        s4_start = 1'b0, s4_signed = 1'b0;
    logic [3:0]  s4_a = '0, s4_b = '0;
    logic        s4_busy, s4_done;
    logic [7:0]  s4_prod;

    logic        s8_start = 1'b0, s8_signed = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_busy, s8_done;
    logic [15:0] s8_prod;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_multi_nbits #(.BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(s4_start), .signed_i(s4_signed),
        .A_i(s4_a), .B_i(s4_b), .busy_o(s4_busy), .done_o(s4_done), .Product_o(s4_prod)
    );

    seq_multi_nbits #(.BITS(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(s8_start), .signed_i(s8_signed),
        .A_i(s8_a), .B_i(s8_b), .busy_o(s8_busy), .done_o(s8_done), .Product_o(s8_prod)
    );

    // Reference: interpret operands per mode, multiply as integers, wrap to 2*bits.
    function automatic longint ref_mul(int bits, bit sgn, longint a, longint b);
        longint sa, sb;
        sa = a;
        sb = b;
        if (sgn) begin
            if (a >= (longint'(1) << (bits - 1))) sa = a - (longint'(1) << bits);
            if (b >= (longint'(1) << (bits - 1))) sb = b - (longint'(1) << bits);
        end
        return (sa * sb) & ((longint'(1) << (2 * bits)) - 1);
    endfunction

    // Launch one BITS=8 multiply from posedge+1 and observe it until done_o.
    task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       output int lat, output int busy_n, output logic [15:0] prod,
                       output logic held, output logic done_low);
        logic [15:0] prev;
        prev = s8_prod;
        s8_a = a; s8_b = b; s8_signed = sgn; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_signed = 1'($urandom);
        done_low = (s8_done === 1'b0);
        busy_n = (s8_busy === 1'b1) ? 1 : 0;
        held = 1'b1;
        lat = 0;
        while (s8_done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (s8_busy === 1'b1) busy_n++;
            if (s8_done !== 1'b1 && s8_prod !== prev) held = 1'b0;
        end
        prod = s8_prod;
    endtask

    task automatic do4(input logic [3:0] a, input logic [3:0] b,
                       output int lat, output int busy_n, output logic [7:0] prod,
                       output logic done_low);
        s4_a = a; s4_b = b; s4_signed = 1'b0; s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        s4_a = 4'($urandom); s4_b = 4'($urandom);
        done_low = (s4_done === 1'b0);
        busy_n = (s4_busy === 1'b1) ? 1 : 0;
        lat = 0;
        while (s4_done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (s4_busy === 1'b1) busy_n++;
        end
        prod = s4_prod;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({s4_busy, s4_done, s4_prod, s8_busy, s8_done, s8_prod} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_async: got b4=%b d4=%b p4=%h b8=%b d8=%b p8=%h, want all 0",
                     s4_busy, s4_done, s4_prod, s8_busy, s8_done, s8_prod);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({s8_busy, s8_done, s8_prod} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got b8=%b d8=%b p8=%h, want 0", s8_busy, s8_done, s8_prod);
        end
    endtask

    task automatic test_exhaustive4();
        int lat, busy_n;
        logic [7:0] prod, exp;
        logic dl;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do4(4'(a), 4'(b), lat, busy_n, prod, dl);
                exp = 8'(ref_mul(4, 1'b0, a, b));
                vectors++;
                if (prod !== exp || lat != 5 || busy_n != 5 || !dl) begin
                    miscompares++;
                    $display("FAIL exh4 %0d*%0d: got p=%h lat=%0d busy=%0d done_low=%b, want p=%h lat=5 busy=5 done_low=1",
                             a, b, prod, lat, busy_n, dl, exp);
                end
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (s4_done !== 1'b0) begin
            miscompares++;
            $display("FAIL exh4_done_pulse: got done=%b one cycle later, want 0", s4_done);
        end
    endtask

    task automatic test_corners8();
        logic [7:0]  ta [8] = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h00};
        logic [7:0]  tb [8] = '{8'hFF, 8'hFF, 8'h80, 8'h01, 8'h81, 8'h85, 8'h7F, 8'h00};
        logic        ts [8] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
        // 127 * -127 = -16129 -> C0FF; -128 * 127 = -16256 -> C080
        logic [15:0] te [8] = '{16'hFE01, 16'h0001, 16'h4000, 16'hFF80,
                                16'hC0FF, 16'h0000, 16'hC080, 16'h0000};
        int lat, busy_n;
        logic [15:0] prod;
        logic held, dl;
        for (int i = 0; i < 8; i++) begin
            do8(ta[i], tb[i], ts[i], lat, busy_n, prod, held, dl);
            vectors++;
            if (prod !== te[i] || lat != 9 || busy_n != 9 || !held || !dl) begin
                miscompares++;
                $display("FAIL corner8[%0d] %h*%h s=%b: got p=%h lat=%0d busy=%0d held=%b, want p=%h lat=9 busy=9 held=1",
                         i, ta[i], tb[i], ts[i], prod, lat, busy_n, held, te[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (s8_done !== 1'b0 || s8_prod !== te[i]) begin
                miscompares++;
                $display("FAIL corner8_after[%0d]: got done=%b p=%h, want done=0 p=%h",
                         i, s8_done, s8_prod, te[i]);
            end
        end
    endtask

    task automatic test_random8();
        int lat, busy_n;
        logic [15:0] prod, exp;
        logic held, dl;
        logic [7:0] a, b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            do8(a, b, s, lat, busy_n, prod, held, dl);
            exp = 16'(ref_mul(8, s, longint'(a), longint'(b)));
            vectors++;
            if (prod !== exp || lat != 9 || !held || !dl) begin
                miscompares++;
                $display("FAIL rand8 %h*%h s=%b: got p=%h lat=%0d held=%b, want p=%h lat=9",
                         a, b, s, prod, lat, held, exp);
            end
        end
    endtask

    // start_i held high: results are accepted every BITS+2 edges (start is only
    // sampled once busy_o has dropped), so pulses land at offsets 9 and 19.
    task automatic test_back_to_back();
        int done_t [$];
        logic [15:0] done_p [$];
        s8_signed = 1'b0; s8_a = 8'd3; s8_b = 8'd5; s8_start = 1'b1;
        @(posedge clk); #1;
        for (int t = 1; t <= 24; t++) begin
            if (t == 10) begin
                s8_a = 8'd7; s8_b = 8'd9;
            end else begin
                s8_a = 8'($urandom_range(10, 255)); s8_b = 8'($urandom_range(10, 255));
            end
            s8_start = (t < 20);
            @(posedge clk); #1;
            if (s8_done === 1'b1) begin
                done_t.push_back(t);
                done_p.push_back(s8_prod);
            end
        end
        vectors++;
        if (done_t.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d done pulses, want 2", done_t.size());
        end else begin
            vectors++;
            if (done_t[0] != 9 || done_t[1] != 19 || done_p[0] !== 16'd15 || done_p[1] !== 16'd63) begin
                miscompares++;
                $display("FAIL b2b_results: got t=%0d,%0d p=%0d,%0d, want t=9,19 p=15,63",
                         done_t[0], done_t[1], done_p[0], done_p[1]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, busy_n, ndone;
        logic [15:0] prod;
        logic held, dl;
        s8_signed = 1'b0; s8_a = 8'd200; s8_b = 8'd100; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (s8_busy !== 1'b0 || s8_prod !== 16'd0 || s8_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: got busy=%b done=%b p=%h, want 0,0,0", s8_busy, s8_done, s8_prod);
        end
        @(posedge clk); #1 rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone != 0 || s8_prod !== 16'd0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses p=%h, want 0 pulses p=0", ndone, s8_prod);
        end
        do8(8'd12, 8'd11, 1'b0, lat, busy_n, prod, held, dl);
        vectors++;
        if (prod !== 16'd132 || lat != 9) begin
            miscompares++;
            $display("FAIL abort_restart: got p=%0d lat=%0d, want p=132 lat=9", prod, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, ndone;
        logic held;
        s8_signed = 1'b0; s8_a = 8'd6; s8_b = 8'd7; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        held = 1'b1;
        lat = 0;
        while (s8_done !== 1'b1 && lat < 40) begin
            s8_start = (lat == 2 || lat == 3);
            s8_a = 8'd1; s8_b = 8'd1;
            @(posedge clk); #1;
            lat++;
            if (s8_done !== 1'b1 && s8_prod !== 16'd132) held = 1'b0;
        end
        s8_start = 1'b0;
        vectors++;
        if (!held || lat != 9 || s8_prod !== 16'd42) begin
            miscompares++;
            $display("FAIL busy_ignore: got held=%b lat=%0d p=%0d, want held=1 lat=9 p=42",
                     held, lat, s8_prod);
        end
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (s8_done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone != 0 || s8_prod !== 16'd42) begin
            miscompares++;
            $display("FAIL busy_ignore_after: got %0d extra pulses p=%0d, want 0 pulses p=42",
                     ndone, s8_prod);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive4();
        test_corners8();
        test_random8();
        test_back_to_back();
        test_reset_abort();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
